// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// FSM states, RV32I funct3 encodings and response error codes.
package lsu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ_WAIT,
    S_WRITE_WAIT,
    S_RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_MISAL = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

endpackage

// File: rtl/lsu_datamem_if_if.sv
// Core request/response and data memory strobe bundle.
// slave = the LSU, master = the core plus memory around it.
interface lsu_datamem_if_if;

  logic        LSU_Req_Valid_In;
  logic        LSU_Req_Ready_Out;
  logic        LSU_Req_Write_In;
  logic [2:0]  LSU_Req_Funct3_In;
  logic [31:0] LSU_Req_Addr_InBUS;
  logic [31:0] LSU_Req_Wdata_InBUS;
  logic        LSU_Rsp_Valid_Out;
  logic [31:0] LSU_Rsp_Rdata_OutBUS;
  logic [1:0]  LSU_Rsp_Error_OutBUS;
  logic        LSU_Datamem_Ready_Out;
  logic        LSU_Datamem_Valid_In;
  logic [31:0] LSU_Datamem_Readdata_InBUS;
  logic        LSU_Datamem_Valid_Out;
  logic        LSU_Datamem_Ready_In;
  logic [31:0] LSU_Datamem_Writedata_OutBUS;
  logic [31:0] LSU_Datamem_Addr_OutBUS;
  logic [3:0]  LSU_Datamem_Byteenable_OutBUS;

  modport slave (
    input  LSU_Req_Valid_In,
    output LSU_Req_Ready_Out,
    input  LSU_Req_Write_In,
    input  LSU_Req_Funct3_In,
    input  LSU_Req_Addr_InBUS,
    input  LSU_Req_Wdata_InBUS,
    output LSU_Rsp_Valid_Out,
    output LSU_Rsp_Rdata_OutBUS,
    output LSU_Rsp_Error_OutBUS,
    output LSU_Datamem_Ready_Out,
    input  LSU_Datamem_Valid_In,
    input  LSU_Datamem_Readdata_InBUS,
    output LSU_Datamem_Valid_Out,
    input  LSU_Datamem_Ready_In,
    output LSU_Datamem_Writedata_OutBUS,
    output LSU_Datamem_Addr_OutBUS,
    output LSU_Datamem_Byteenable_OutBUS
  );

  modport master (
    output LSU_Req_Valid_In,
    input  LSU_Req_Ready_Out,
    output LSU_Req_Write_In,
    output LSU_Req_Funct3_In,
    output LSU_Req_Addr_InBUS,
    output LSU_Req_Wdata_InBUS,
    input  LSU_Rsp_Valid_Out,
    input  LSU_Rsp_Rdata_OutBUS,
    input  LSU_Rsp_Error_OutBUS,
    input  LSU_Datamem_Ready_Out,
    output LSU_Datamem_Valid_In,
    output LSU_Datamem_Readdata_InBUS,
    input  LSU_Datamem_Valid_Out,
    output LSU_Datamem_Ready_In,
    input  LSU_Datamem_Writedata_OutBUS,
    input  LSU_Datamem_Addr_OutBUS,
    input  LSU_Datamem_Byteenable_OutBUS
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication,
// load shift/extend and access legality checks.
module lsu_align
  import lsu_pkg::*;
(
  input  logic            write,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_ext,
  output logic            misal,
  output logic            ill
);

  logic            is_b;
  logic            is_h;
  logic            is_w;
  logic [XLEN-1:0] shifted;

  assign is_b = (funct3[1:0] == 2'b00);
  assign is_h = (funct3[1:0] == 2'b01);
  assign is_w = (funct3[1:0] == 2'b10);

  // Stores only have B/H/W; loads add BU/HU.
  always_comb begin
    if (write)
      ill = (funct3 >= 3'd3);
    else
      ill = (funct3 == 3'd3) || (funct3 == 3'd6) ||
            (funct3 == 3'd7);
  end

  assign misal = (is_h && addr_lo[0]) ||
                 (is_w && (addr_lo != 2'b00));

  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      is_h: begin
        be        = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      is_w: begin
        be        = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = '0;
      end
    endcase
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_ext = '0;
    unique case (funct3)
      F3_B:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:  load_ext = shifted;
      F3_BU: load_ext = {24'b0, shifted[7:0]};
      F3_HU: load_ext = {16'b0, shifted[15:0]};
      default: load_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu_datamem_if.sv
// Load/store unit: one outstanding access, registered memory
// strobes, timeout abort and one-cycle response pulse.
module lsu_datamem_if
  import lsu_pkg::*;
#(
  parameter int DATAWIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic LSU_Clk_In,
  input logic LSU_Reset_In,
  lsu_datamem_if_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  lsu_state_t           state;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic [DATAWIDTH-1:0] rsp_rdata_q;
  logic [1:0]           rsp_err_q;
  logic                 rd_stb_q;
  logic                 wr_stb_q;
  logic [DATAWIDTH-1:0] mem_addr_q;
  logic [DATAWIDTH-1:0] mem_wdata_q;
  logic [3:0]           mem_be_q;
  logic [TW-1:0]        tmo_q;

  logic                 wr_q;
  logic [2:0]           f3_q;
  logic [DATAWIDTH-1:0] addr_q;
  logic [DATAWIDTH-1:0] wdata_q;

  logic                 sel_req;
  logic                 al_write;
  logic [2:0]           al_f3;
  logic [DATAWIDTH-1:0] al_addr;
  logic [DATAWIDTH-1:0] al_wdata;
  logic [3:0]           al_be;
  logic [DATAWIDTH-1:0] al_rep;
  logic [DATAWIDTH-1:0] al_ext;
  logic                 al_misal;
  logic                 al_ill;

  // Decode live request in IDLE, latched request afterwards.
  assign sel_req  = (state == S_IDLE);
  assign al_write = sel_req ? bus.LSU_Req_Write_In  : wr_q;
  assign al_f3    = sel_req ? bus.LSU_Req_Funct3_In : f3_q;
  assign al_addr  = sel_req ? bus.LSU_Req_Addr_InBUS : addr_q;
  assign al_wdata = sel_req ? bus.LSU_Req_Wdata_InBUS : wdata_q;

  lsu_align u_align (
    .write     (al_write),
    .funct3    (al_f3),
    .addr_lo   (al_addr[1:0]),
    .wdata     (al_wdata),
    .rdata     (bus.LSU_Datamem_Readdata_InBUS),
    .be        (al_be),
    .wdata_rep (al_rep),
    .load_ext  (al_ext),
    .misal     (al_misal),
    .ill       (al_ill)
  );

  always_ff @(posedge LSU_Clk_In or posedge LSU_Reset_In) begin
    if (LSU_Reset_In) begin
      state       <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= 4'b0000;
      tmo_q       <= '0;
      wr_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.LSU_Req_Valid_In && req_ready_q) begin
            wr_q        <= bus.LSU_Req_Write_In;
            f3_q        <= bus.LSU_Req_Funct3_In;
            addr_q      <= bus.LSU_Req_Addr_InBUS;
            wdata_q     <= bus.LSU_Req_Wdata_InBUS;
            req_ready_q <= 1'b0;
            tmo_q       <= '0;
            if (al_ill || al_misal) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
              rsp_err_q   <= al_ill ? ERR_ILL : ERR_MISAL;
            end else begin
              mem_addr_q  <= {bus.LSU_Req_Addr_InBUS[31:2],
                              2'b00};
              mem_be_q    <= al_be;
              mem_wdata_q <= bus.LSU_Req_Write_In ? al_rep : '0;
              if (bus.LSU_Req_Write_In) begin
                wr_stb_q <= 1'b1;
                state    <= S_WRITE_WAIT;
              end else begin
                rd_stb_q <= 1'b1;
                state    <= S_READ_WAIT;
              end
            end
          end
        end
        S_READ_WAIT: begin
          if (bus.LSU_Datamem_Valid_In) begin
            rd_stb_q    <= 1'b0;
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= al_ext;
            rsp_err_q   <= ERR_OK;
          end else if (tmo_q == TMO_LAST) begin
            rd_stb_q    <= 1'b0;
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_TMO;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WRITE_WAIT: begin
          if (bus.LSU_Datamem_Ready_In) begin
            wr_stb_q    <= 1'b0;
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_OK;
          end else if (tmo_q == TMO_LAST) begin
            wr_stb_q    <= 1'b0;
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_TMO;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state       <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.LSU_Req_Ready_Out             = req_ready_q;
  assign bus.LSU_Rsp_Valid_Out             = rsp_valid_q;
  assign bus.LSU_Rsp_Rdata_OutBUS          = rsp_rdata_q;
  assign bus.LSU_Rsp_Error_OutBUS          = rsp_err_q;
  assign bus.LSU_Datamem_Ready_Out         = rd_stb_q;
  assign bus.LSU_Datamem_Valid_Out         = wr_stb_q;
  assign bus.LSU_Datamem_Writedata_OutBUS  = mem_wdata_q;
  assign bus.LSU_Datamem_Addr_OutBUS       = mem_addr_q;
  assign bus.LSU_Datamem_Byteenable_OutBUS = mem_be_q;

endmodule

// File: tb/tb_lsu_datamem_if.sv
// Directed bench for lsu_datamem_if with TIMEOUT_CYCLES=8.
// Inputs change on negedge or #1 after posedge; checks on negedge.
module tb_lsu_datamem_if;

  logic tb_clk_50;
  logic tb_rst;
  int   total;
  int   bad;

  lsu_datamem_if_if bus ();

  lsu_datamem_if #(
    .DATAWIDTH      (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .LSU_Clk_In   (tb_clk_50),
    .LSU_Reset_In (tb_rst),
    .bus          (bus)
  );

  initial tb_clk_50 = 1'b0;
  always #10 tb_clk_50 = ~tb_clk_50;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    @(negedge tb_clk_50);
    bus.LSU_Req_Valid_In    = 1'b1;
    bus.LSU_Req_Write_In    = wr;
    bus.LSU_Req_Funct3_In   = f3;
    bus.LSU_Req_Addr_InBUS  = a;
    bus.LSU_Req_Wdata_InBUS = wd;
    @(posedge tb_clk_50);
    #1;
    bus.LSU_Req_Valid_In = 1'b0;
  endtask

  task automatic mem_op(input string tag, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] word,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wd, input logic [31:0] e_rd);
    bus.LSU_Datamem_Readdata_InBUS = word;
    issue(wr, f3, a, wd);
    if (wr) bus.LSU_Datamem_Ready_In = 1'b1;
    else    bus.LSU_Datamem_Valid_In = 1'b1;
    @(negedge tb_clk_50);
    chk({tag, "_stb"},
        {31'b0, wr ? bus.LSU_Datamem_Valid_Out
                   : bus.LSU_Datamem_Ready_Out}, 32'd1);
    chk({tag, "_rdy_busy"}, {31'b0, bus.LSU_Req_Ready_Out}, 32'd0);
    chk({tag, "_addr"}, bus.LSU_Datamem_Addr_OutBUS, e_addr);
    chk({tag, "_be"}, {28'b0, bus.LSU_Datamem_Byteenable_OutBUS},
        {28'b0, e_be});
    if (wr)
      chk({tag, "_wd"}, bus.LSU_Datamem_Writedata_OutBUS, e_wd);
    @(posedge tb_clk_50);
    #1;
    bus.LSU_Datamem_Ready_In = 1'b0;
    bus.LSU_Datamem_Valid_In = 1'b0;
    @(negedge tb_clk_50);
    chk({tag, "_rsp"}, {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd1);
    chk({tag, "_err"}, {30'b0, bus.LSU_Rsp_Error_OutBUS}, 32'd0);
    chk({tag, "_rdata"}, bus.LSU_Rsp_Rdata_OutBUS, e_rd);
    @(negedge tb_clk_50);
    chk({tag, "_rsp_end"}, {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd0);
    chk({tag, "_rdy_back"}, {31'b0, bus.LSU_Req_Ready_Out}, 32'd1);
  endtask

  task automatic err_op(input string tag, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [1:0] e_err);
    issue(wr, f3, a, 32'hFFFF_FFFF);
    @(negedge tb_clk_50);
    chk({tag, "_rsp"}, {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd1);
    chk({tag, "_err"}, {30'b0, bus.LSU_Rsp_Error_OutBUS},
        {30'b0, e_err});
    chk({tag, "_rdata"}, bus.LSU_Rsp_Rdata_OutBUS, 32'd0);
    chk({tag, "_nostb"},
        {30'b0, bus.LSU_Datamem_Ready_Out, bus.LSU_Datamem_Valid_Out},
        32'd0);
    @(negedge tb_clk_50);
    chk({tag, "_rsp_end"}, {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd0);
    chk({tag, "_rdy_back"}, {31'b0, bus.LSU_Req_Ready_Out}, 32'd1);
  endtask

  initial begin
    int  hi;
    bit  done;
    total = 0;
    bad   = 0;
    tb_rst = 1'b1;
    bus.LSU_Req_Valid_In           = 1'b0;
    bus.LSU_Req_Write_In           = 1'b0;
    bus.LSU_Req_Funct3_In          = 3'b000;
    bus.LSU_Req_Addr_InBUS         = 32'h0;
    bus.LSU_Req_Wdata_InBUS        = 32'h0;
    bus.LSU_Datamem_Valid_In       = 1'b0;
    bus.LSU_Datamem_Ready_In       = 1'b0;
    bus.LSU_Datamem_Readdata_InBUS = 32'h0;
    repeat (2) @(negedge tb_clk_50);
    tb_rst = 1'b0;
    @(negedge tb_clk_50);

    chk("rst_ready", {31'b0, bus.LSU_Req_Ready_Out}, 32'd1);
    chk("rst_rsp", {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd0);
    chk("rst_rdata", bus.LSU_Rsp_Rdata_OutBUS, 32'd0);
    chk("rst_err", {30'b0, bus.LSU_Rsp_Error_OutBUS}, 32'd0);
    chk("rst_stb",
        {30'b0, bus.LSU_Datamem_Ready_Out, bus.LSU_Datamem_Valid_Out},
        32'd0);
    chk("rst_addr", bus.LSU_Datamem_Addr_OutBUS, 32'd0);
    chk("rst_wd", bus.LSU_Datamem_Writedata_OutBUS, 32'd0);
    chk("rst_be", {28'b0, bus.LSU_Datamem_Byteenable_OutBUS}, 32'd0);

    mem_op("sw", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0,
           32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    mem_op("sb", 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0,
           32'h10, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    mem_op("sh", 1'b1, 3'b001, 32'h12, 32'h0000_1234, 32'h0,
           32'h10, 4'b1100, 32'h1234_1234, 32'h0);
    mem_op("lb", 1'b0, 3'b000, 32'h22, 32'h0, 32'h0080_0000,
           32'h20, 4'b0100, 32'h0, 32'hFFFF_FF80);
    mem_op("lbu", 1'b0, 3'b100, 32'h22, 32'h0, 32'h0080_0000,
           32'h20, 4'b0100, 32'h0, 32'h0000_0080);
    mem_op("lh", 1'b0, 3'b001, 32'h22, 32'h0, 32'h8001_0000,
           32'h20, 4'b1100, 32'h0, 32'hFFFF_8001);
    mem_op("lhu", 1'b0, 3'b101, 32'h22, 32'h0, 32'h8001_0000,
           32'h20, 4'b1100, 32'h0, 32'h0000_8001);
    mem_op("lw", 1'b0, 3'b010, 32'h44, 32'h0, 32'hCAFE_F00D,
           32'h44, 4'b1111, 32'h0, 32'hCAFE_F00D);

    err_op("lw_mis", 1'b0, 3'b010, 32'h06, 2'b01);
    err_op("lh_mis", 1'b0, 3'b001, 32'h23, 2'b01);
    err_op("ld_ill", 1'b0, 3'b011, 32'h00, 2'b11);
    err_op("st_ill", 1'b1, 3'b101, 32'h01, 2'b11);

    bus.LSU_Datamem_Valid_In = 1'b0;
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    hi   = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge tb_clk_50);
      if (bus.LSU_Datamem_Ready_Out) hi++;
      if (bus.LSU_Rsp_Valid_Out) begin
        done = 1'b1;
        chk("tmo_err", {30'b0, bus.LSU_Rsp_Error_OutBUS}, 32'd2);
        chk("tmo_rdata", bus.LSU_Rsp_Rdata_OutBUS, 32'd0);
      end
    end
    chk("tmo_seen", {31'b0, done}, 32'd1);
    chk("tmo_hi_cycles", hi, 32'd8);
    @(negedge tb_clk_50);

    bus.LSU_Datamem_Readdata_InBUS = 32'h1122_3344;
    issue(1'b0, 3'b010, 32'h40, 32'h0);
    repeat (7) @(posedge tb_clk_50);
    #1;
    bus.LSU_Datamem_Valid_In = 1'b1;
    @(negedge tb_clk_50);
    chk("last_stb", {31'b0, bus.LSU_Datamem_Ready_Out}, 32'd1);
    chk("last_norsp", {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd0);
    @(posedge tb_clk_50);
    #1;
    bus.LSU_Datamem_Valid_In = 1'b0;
    @(negedge tb_clk_50);
    chk("last_rsp", {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd1);
    chk("last_err", {30'b0, bus.LSU_Rsp_Error_OutBUS}, 32'd0);
    chk("last_rdata", bus.LSU_Rsp_Rdata_OutBUS, 32'h1122_3344);
    @(negedge tb_clk_50);

    bus.LSU_Datamem_Valid_In = 1'b1;
    @(negedge tb_clk_50);
    chk("idle_ignore_rsp", {31'b0, bus.LSU_Rsp_Valid_Out}, 32'd0);
    bus.LSU_Datamem_Valid_In = 1'b0;

    issue(1'b0, 3'b010, 32'h80, 32'h0);
    @(negedge tb_clk_50);
    chk("rst_mid_stb_before", {31'b0, bus.LSU_Datamem_Ready_Out},
        32'd1);
    #2;
    tb_rst = 1'b1;
    #1;
    chk("rst_mid_stb_drop", {31'b0, bus.LSU_Datamem_Ready_Out}, 32'd0);
    @(negedge tb_clk_50);
    tb_rst = 1'b0;
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge tb_clk_50);
      if (bus.LSU_Rsp_Valid_Out) hi++;
    end
    chk("rst_mid_norsp", hi, 32'd0);
    chk("rst_mid_ready", {31'b0, bus.LSU_Req_Ready_Out}, 32'd1);
    chk("rst_mid_nostb", {31'b0, bus.LSU_Datamem_Ready_Out}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_datamem_if.md
Name: lsu_datamem_if

Overview:
Load/store unit between the core's execute stage and the data memory ready/valid interface. Accepts one load or store request at a time and builds the word-aligned address, byte-enables and lane-replicated write data. On loads, it extracts and sign- or zero-extends the returned data. Misaligned, illegal and timed-out accesses return an error code instead of hanging the pipeline.

Parameters:
DATAWIDTH, 32, data/address bus width (only 32 supported)
TIMEOUT_CYCLES, 256, max cycles a memory strobe is held before aborting (>=2)

Ports:
LSU_Clk_In  in  1  clock
LSU_Reset_In  in  1  reset, asynchronous, active-high
LSU_Req_Valid_In  in  1  core request valid
LSU_Req_Ready_Out  out  1  unit can accept request
LSU_Req_Write_In  in  1  1=store, 0=load
LSU_Req_Funct3_In  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
LSU_Req_Addr_InBUS  in  32  byte address
LSU_Req_Wdata_InBUS  in  32  store data (low bits significant)
LSU_Rsp_Valid_Out  out  1  one-cycle response pulse
LSU_Rsp_Rdata_OutBUS  out  32  extended load data
LSU_Rsp_Error_OutBUS  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3
LSU_Datamem_Ready_Out  out  1  read strobe to memory
LSU_Datamem_Valid_In  in  1  memory read data valid
LSU_Datamem_Readdata_InBUS  in  32  memory read word
LSU_Datamem_Valid_Out  out  1  write strobe to memory
LSU_Datamem_Ready_In  in  1  memory write accepted
LSU_Datamem_Writedata_OutBUS  out  32  write word
LSU_Datamem_Addr_OutBUS  out  32  word address, bits[1:0]=00
LSU_Datamem_Byteenable_OutBUS  out  4  lane enables

Behaviour:
- Reset: state IDLE. Req_Ready=1. Rsp_Valid=0, Rdata=0, Error=00. Both strobes=0. Addr/Writedata/Byteenable=0. Timeout counter=0.
- States: IDLE, READ_WAIT, WRITE_WAIT, RESP.
- IDLE: Req_Ready=1. On Valid&Ready, latch write, funct3, addr and wdata.
  - Illegal funct3 (load 3/6/7, store >=3) -> RESP, error 11.
  - Else misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> RESP, error 01.
  - Else -> READ_WAIT or WRITE_WAIT.
  - Illegal is checked before misaligned.
- Req_Ready=0 in every state except IDLE.
- Byte-enables:
  - B: 4'b0001<<addr[1:0]
  - H: 4'b0011<<{addr[1],1'b0}
  - W: 4'b1111
  - Applied to loads and stores.
- Write data: B -> {4{wdata[7:0]}}; H -> {2{wdata[15:0]}}; W -> wdata.
- READ_WAIT: Datamem_Ready_Out=1. Addr and Byteenable are registered and stable. When Datamem_Valid_In=1 is sampled, capture the data and go to RESP, error 00.
- WRITE_WAIT: Datamem_Valid_Out=1. Addr, Writedata and Byteenable are stable. When Datamem_Ready_In=1 is sampled, go to RESP, error 00.
- Memory handshake inputs are ignored outside their wait state.
- Timeout counter:
  - Cleared on entry to a wait state; increments each wait cycle.
  - If no handshake by count TIMEOUT_CYCLES-1, drop the strobe and go to RESP with error 10.
  - The strobe is therefore high for at most TIMEOUT_CYCLES cycles.
  - A handshake in the final cycle wins over timeout.
- Load extract: shift the word right by addr[1:0]*8. LB/LH sign-extend; LBU/LHU zero-extend.
- RESP: Rsp_Valid=1 for exactly one cycle, then IDLE. There is no response backpressure. Rdata=0 for stores and for any error.
- Latency:
  - Request accepted at edge N; strobe high during cycle N+1.
  - Memory handshake in cycle N+1 -> Rsp_Valid during N+2.
  - Error at accept -> Rsp_Valid during N+1.
  - Peak throughput is one op per 3 cycles.
- Reset mid-operation: strobes drop immediately (async), state returns to IDLE, and the pending request is discarded with no response.

Decomposition:
- Package lsu_pkg:
  - state enum
  - funct3 constants (F3_B/H/W/BU/HU)
  - error code constants (ERR_OK/MISAL/TMO/ILL)
- Sub-module lsu_align (combinational):
  - byte-enable generation
  - store lane replication
  - load shift/extend
  - misalign/illegal detection
- The top module holds the FSM, registers and timeout counter.

Test Plan:
1. SW addr 0x10, wdata 0xDEADBEEF, Ready_In=1 on first strobe cycle -> Addr 0x10, BE 1111, Writedata 0xDEADBEEF; Rsp_Valid 2 cycles after accept, Error 00.
2. SB addr 0x13, wdata 0x000000A5 -> BE 1000, Writedata 0xA5A5A5A5, Addr 0x10. SH addr 0x12, wdata 0x1234 -> BE 1100.
3. LB addr 0x22, memory returns 0x00800000 -> Rdata 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x22, memory 0x80010000 -> 0xFFFF8001. LHU -> 0x00008001.
4. LW addr 0x06 -> no strobe, Rsp_Valid 1 cycle after accept, Error 01. Load funct3=3'b011 -> Error 11.
5. TIMEOUT_CYCLES=8, load with Valid_In held 0 -> Datamem_Ready_Out high exactly 8 cycles, then Error 10, Rdata 0. Repeat with Valid_In=1 in the 8th cycle -> Error 00.
6. Assert reset mid-READ_WAIT -> Datamem_Ready_Out low before the next edge, no Rsp_Valid, Req_Ready=1 after release.
